// File: rtl/vga_pixel_out.sv
// vga_pixel_out: final display stage behind the object priority mux.
// Generates the raster counters (pixelX/pixelY/startOfFrame) consumed by the
// object drawers, expands the mux's RGB332 pixel to 8:8:8 and drives the VGA
// pins with sync/blank delay-matched to the drawer+mux pipeline.
// Optional feature: define VGA_TEST_PATTERN_EN to let testModeEn replace the
// incoming pixel with 64-pixel colour bars; otherwise testModeEn is ignored.
module vga_pixel_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_LAT = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  RGBIn,
  input  logic        testModeEn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic [7:0]  vgaR,
  output logic [7:0]  vgaG,
  output logic [7:0]  vgaB,
  output logic        hsyncN,
  output logic        vsyncN,
  output logic        blankN
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic       hs;
  logic       vs;
  logic       act;
  // {hs, vs, act} per stage; stage PIPE_LAT-1 lines up with RGBIn
  logic [2:0] tim_pipe [PIPE_LAT];
  logic [2:0] tim_d;
  logic [7:0] pix_sel;

  // Raster counters: pixelX every clock, pixelY on each line wrap
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pixelX <= '0;
      pixelY <= '0;
    end else if (pixelX == H_LAST) begin
      pixelX <= '0;
      pixelY <= (pixelY == V_LAST) ? 11'd0 : pixelY + 11'd1;
    end else begin
      pixelX <= pixelX + 11'd1;
    end
  end

  // Frame pulse: registered from the (0,0) position, so it follows reset
  // release by one clock and never fires for a partial frame
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) startOfFrame <= 1'b0;
    else         startOfFrame <= (pixelX == 11'd0) && (pixelY == 11'd0);
  end

  // Raw sync/active decode straight from the counters
  always_comb begin
    hs  = (pixelX >= HS_FIRST) && (pixelX < HS_END);
    vs  = (pixelY >= VS_FIRST) && (pixelY < VS_END);
    act = (pixelX < H_ACT) && (pixelY < V_ACT);
  end

  // Delay timing by the drawer+mux latency so it meets RGBIn
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < PIPE_LAT; i++) tim_pipe[i] <= 3'b000;
    end else begin
      tim_pipe[0] <= {hs, vs, act};
      for (int i = 1; i < PIPE_LAT; i++) tim_pipe[i] <= tim_pipe[i-1];
    end
  end

  assign tim_d = tim_pipe[PIPE_LAT-1];

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar_pipe [PIPE_LAT];
  logic [2:0] bar;

  // Bar index follows the same delay as the timing so bars stay pixel-aligned
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < PIPE_LAT; i++) bar_pipe[i] <= 3'b000;
    end else begin
      bar_pipe[0] <= pixelX[8:6];
      for (int i = 1; i < PIPE_LAT; i++) bar_pipe[i] <= bar_pipe[i-1];
    end
  end

  assign bar = bar_pipe[PIPE_LAT-1];

  // Colour-bar substitution ahead of expansion and blanking
  always_comb begin
    pix_sel = RGBIn;
    if (testModeEn) pix_sel = {{3{bar[2]}}, {3{bar[1]}}, {2{bar[0]}}};
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = testModeEn;

  // Without the test pattern the mux pixel passes straight through
  always_comb begin
    pix_sel = RGBIn;
  end
`endif

  // Output register: sync polarity, blanking and RGB332 -> 888 replication
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hsyncN <= 1'b1;
      vsyncN <= 1'b1;
      blankN <= 1'b0;
      vgaR   <= 8'h00;
      vgaG   <= 8'h00;
      vgaB   <= 8'h00;
    end else begin
      hsyncN <= ~tim_d[2];
      vsyncN <= ~tim_d[1];
      blankN <= tim_d[0];
      if (tim_d[0]) begin
        vgaR <= {pix_sel[7:5], pix_sel[7:5], pix_sel[7:6]};
        vgaG <= {pix_sel[4:2], pix_sel[4:2], pix_sel[4:3]};
        vgaB <= {pix_sel[1:0], pix_sel[1:0], pix_sel[1:0], pix_sel[1:0]};
      end else begin
        vgaR <= 8'h00;
        vgaG <= 8'h00;
        vgaB <= 8'h00;
      end
    end
  end

endmodule
